// File: rtl/uv_uart_txq_pkg.sv
// rtl/uv_uart_txq_pkg.sv - shared FSM state codes, parity codes and small helpers for the UART transmitter
package uv_uart_txq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP0  = 3'd4,
        ST_STOP1  = 3'd5,
        ST_BREAK  = 3'd6
    } tx_state_e;

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_EVEN  = 2'b11;

    // Number of data bits in a frame: nbits+5, with every code >= 4 meaning 9.
    function automatic logic [3:0] data_bits(input logic [2:0] nbits);
        return (nbits >= 3'd4) ? 4'd9 : ({1'b0, nbits} + 4'd5);
    endfunction

    // Parity bit from the XOR of the valid data bits.
    function automatic logic parity_bit(input logic [1:0] ptype, input logic p);
        logic b;
        case (ptype)
            PAR_SPACE: b = 1'b0;
            PAR_MARK:  b = 1'b1;
            PAR_ODD:   b = ~p;
            default:   b = p;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uv_uart_fifo.sv
// rtl/uv_uart_fifo.sv - synchronous FIFO with vld/rdy push, pop strobe and occupancy count
module uv_uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign push_rdy = (cnt_q != FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign cnt      = cnt_q;
    assign pop_dat  = mem_q[rd_ptr_q];
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop & ~empty;

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/uv_uart_txq.sv
// rtl/uv_uart_txq.sv - UART transmitter with TX FIFO, 5..9 data bits, parity, CTS flow control and break
module uv_uart_txq
    import uv_uart_txq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIV_W   = 16,
    parameter int MAX_DBW = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    input  logic [2:0]             nbits,
    input  logic                   nstop,
    input  logic                   endian,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic                   parity_en,
    input  logic [1:0]             parity_type,
    input  logic                   cts_en,
    input  logic                   uart_cts_n,
    input  logic                   brk_req,
    input  logic                   wr_vld,
    output logic                   wr_rdy,
    input  logic [MAX_DBW-1:0]     wr_dat,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   uart_tx
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);

    tx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [3:0]           nb_q, nb_d;
    logic                 nstop_q, nstop_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;
    logic [MAX_DBW-1:0]   shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 cts_s1_q, cts_s1_d;
    logic                 cts_s2_q, cts_s2_d;

    logic                 pop;
    logic [MAX_DBW-1:0]   fifo_dat;
    logic                 fifo_empty;
    logic                 cts_ok, go;
    logic [DIV_W-1:0]     eff_div, cnt_next;
    logic                 bit_end;
    logic [3:0]           nb_new;
    logic [MAX_DBW-1:0]   word_mask, word_rev;
    logic                 start_frame, enter_break, frame_end;

    uv_uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MAX_DBW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (wr_vld),
        .push_rdy (wr_rdy),
        .push_dat (wr_dat),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    assign cts_s1_d = uart_cts_n;
    assign cts_s2_d = cts_s1_q;
    assign cts_ok   = ~cts_en | ~cts_s2_q;
    assign go       = tx_en & ~fifo_empty & cts_ok & ~brk_req;
    assign eff_div  = (clk_div < DIV_TWO) ? DIV_TWO : clk_div;
    assign bit_end  = (cnt_q == div_q - DIV_ONE);
    assign cnt_next = bit_end ? '0 : cnt_q + DIV_ONE;
    assign nb_new   = data_bits(nbits);

    assign uart_tx  = tx_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != ST_IDLE);

    // Head word trimmed to the frame width, plus its bit-reversal within that width for MSB-first.
    always_comb begin
        word_mask = '0;
        word_rev  = '0;
        for (int i = 0; i < MAX_DBW; i++) begin
            if (i < int'(nb_new)) begin
                word_mask[i] = fifo_dat[i];
            end
            for (int j = 0; j < MAX_DBW; j++) begin
                if (i + j == int'(nb_new) - 1) begin
                    word_rev[i] = fifo_dat[j];
                end
            end
        end
    end

    // Frame sequencer: baud counter, bit shifter, frame-boundary decisions and the next line level.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        nb_d        = nb_q;
        nstop_d     = nstop_q;
        par_en_d    = par_en_q;
        par_d       = par_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        start_frame = 1'b0;
        enter_break = 1'b0;
        frame_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (brk_req && tx_en) begin
                    enter_break = 1'b1;
                end else if (go) begin
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == nb_q - 4'd1) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    state_d = ST_STOP0;
                end
            end
            ST_STOP0: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    if (nstop_q) begin
                        state_d = ST_STOP1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            ST_STOP1: begin
                cnt_d = cnt_next;
                if (bit_end) begin
                    frame_end = 1'b1;
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (!brk_req) begin
                    state_d = ST_STOP0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // At a frame boundary break wins over queued data; queued data restarts with no gap.
        if (frame_end) begin
            done_d = 1'b1;
            if (brk_req && tx_en) begin
                enter_break = 1'b1;
            end else if (go) begin
                start_frame = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // Snapshot the configuration so mid-frame changes only affect the next frame.
        if (start_frame) begin
            state_d   = ST_START;
            pop       = 1'b1;
            cnt_d     = '0;
            div_d     = eff_div;
            bit_idx_d = '0;
            nb_d      = nb_new;
            nstop_d   = nstop;
            par_en_d  = parity_en;
            par_d     = parity_bit(parity_type, ^word_mask);
            shift_d   = endian ? word_rev : word_mask;
        end

        // Break ends with exactly one stop period of mark, independent of nstop.
        if (enter_break) begin
            state_d = ST_BREAK;
            cnt_d   = '0;
            div_d   = eff_div;
            nstop_d = 1'b0;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = 1'b1;
        endcase
    end

    // State, datapath and registered line/done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_TWO;
            bit_idx_q <= '0;
            nb_q      <= 4'd5;
            nstop_q   <= 1'b0;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            cts_s1_q  <= 1'b1;
            cts_s2_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            nb_q      <= nb_d;
            nstop_q   <= nstop_d;
            par_en_q  <= par_en_d;
            par_q     <= par_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            cts_s1_q  <= cts_s1_d;
            cts_s2_q  <= cts_s2_d;
        end
    end

endmodule

// File: tb/tb_uv_uart_txq.sv
// tb/tb_uv_uart_txq.sv - directed self-checking bench for uv_uart_txq
module tb_uv_uart_txq;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [2:0]  nbits;
    logic        nstop;
    logic        endian;
    logic [15:0] clk_div;
    logic        parity_en;
    logic [1:0]  parity_type;
    logic        cts_en;
    logic        uart_cts_n;
    logic        brk_req;
    logic        wr_vld;
    logic        wr_rdy;
    logic [8:0]  wr_dat;
    logic [2:0]  fifo_cnt;
    logic        tx_busy;
    logic        tx_done;
    logic        uart_tx;

    int n_cmp = 0;
    int n_bad = 0;

    logic samp_tx   [0:255];
    logic samp_done [0:255];

    always #5 clk = ~clk;

    uv_uart_txq #(
        .DEPTH   (4),
        .DIV_W   (16),
        .MAX_DBW (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .nbits       (nbits),
        .nstop       (nstop),
        .endian      (endian),
        .clk_div     (clk_div),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .cts_en      (cts_en),
        .uart_cts_n  (uart_cts_n),
        .brk_req     (brk_req),
        .wr_vld      (wr_vld),
        .wr_rdy      (wr_rdy),
        .wr_dat      (wr_dat),
        .fifo_cnt    (fifo_cnt),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .uart_tx     (uart_tx)
    );

    function automatic logic [15:0] str2v(input string s);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[i] = (s[i] == "1");
        return v;
    endfunction

    function automatic logic [15:0] frame_bits(input int base, input int div, input int n);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = samp_tx[base + k*div + div/2];
        return v;
    endfunction

    function automatic int cyc_err(input int base, input int div, input string s);
        int e;
        e = 0;
        for (int i = 0; i < s.len()*div; i++) begin
            if (samp_tx[base + i] !== (s[i/div] == "1")) e++;
        end
        return e;
    endfunction

    function automatic int done_count(input int from, input int to);
        int c;
        c = 0;
        for (int i = from; i <= to; i++) if (samp_done[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic set_cfg(input int nb, input int ns, input int en, input int div, input int pe, input int pt);
        nbits       = 3'(nb);
        nstop       = 1'(ns);
        endian      = 1'(en);
        clk_div     = 16'(div);
        parity_en   = 1'(pe);
        parity_type = 2'(pt);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        tx_en      = 1'b1;
        cts_en     = 1'b0;
        uart_cts_n = 1'b1;
        brk_req    = 1'b0;
        wr_vld     = 1'b0;
        wr_dat     = '0;
        set_cfg(3, 0, 0, 2, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push(input logic [8:0] d);
        wr_vld = 1'b1;
        wr_dat = d;
        @(negedge clk);
        wr_vld = 1'b0;
    endtask

    task automatic wait_low(input int limit, output int waited);
        waited = 0;
        while (uart_tx !== 1'b0 && waited < limit) begin
            @(negedge clk);
            waited++;
        end
        if (uart_tx !== 1'b0) waited = -1;
    endtask

    task automatic record(input int n, input int brk_rel);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            samp_tx[i]   = uart_tx;
            samp_done[i] = tx_done;
            if (i == brk_rel) brk_req = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_en = 1'b0; cts_en = 1'b0; uart_cts_n = 1'b1; brk_req = 1'b0;
        wr_vld = 1'b0; wr_dat = '0;
        set_cfg(3, 0, 0, 4, 0, 0);
        repeat (2) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_wr_rdy: got %b expected 1", wr_rdy); end
        n_cmp++; if (fifo_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_fifo_cnt: got %0d expected 0", fifo_cnt); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        do_reset();
        set_cfg(3, 0, 0, 4, 0, 0);
        wr_vld = 1'b1; wr_dat = 9'h0A5;
        @(negedge clk);
        wr_vld = 1'b0;
        n_cmp++; if (uart_tx !== 1'b1 || fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL t1_after_push: got tx=%b cnt=%0d expected tx=1 cnt=1", uart_tx, fifo_cnt); end
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0 || fifo_cnt !== 3'd0 || tx_busy !== 1'b1) begin n_bad++; $display("FAIL t1_start_latency: got tx=%b cnt=%0d busy=%b expected tx=0 cnt=0 busy=1", uart_tx, fifo_cnt, tx_busy); end
        record(41, -1);
        n_cmp++; if (frame_bits(0, 4, 10) !== str2v("0101001011")) begin n_bad++; $display("FAIL t1_frame: got %h expected %h", frame_bits(0, 4, 10), str2v("0101001011")); end
        n_cmp++; if (cyc_err(0, 4, "0101001011") !== 0) begin n_bad++; $display("FAIL t1_bit_width: got %0d wrong cycles expected 0", cyc_err(0, 4, "0101001011")); end
        n_cmp++; if (done_count(0, 40) !== 1 || samp_done[40] !== 1'b1) begin n_bad++; $display("FAIL t1_done: got count=%0d at40=%b expected count=1 at40=1", done_count(0, 40), samp_done[40]); end
        n_cmp++; if (samp_tx[40] !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL t1_idle_after: got tx=%b busy=%b expected tx=1 busy=0", samp_tx[40], tx_busy); end
    endtask

    task automatic test_parity();
        int w;
        do_reset();
        set_cfg(2, 1, 1, 3, 1, 3);
        push(9'h035);
        wait_low(20, w);
        record(34, -1);
        n_cmp++; if (frame_bits(0, 3, 11) !== str2v("00110101011")) begin n_bad++; $display("FAIL t2_even_frame: got %h expected %h", frame_bits(0, 3, 11), str2v("00110101011")); end
        n_cmp++; if (done_count(0, 33) !== 1 || samp_done[33] !== 1'b1) begin n_bad++; $display("FAIL t2_even_done: got count=%0d at33=%b expected count=1 at33=1", done_count(0, 33), samp_done[33]); end
        set_cfg(2, 1, 1, 3, 1, 2);
        push(9'h035);
        wait_low(20, w);
        record(34, -1);
        n_cmp++; if (frame_bits(0, 3, 11) !== str2v("00110101111")) begin n_bad++; $display("FAIL t2_odd_frame: got %h expected %h", frame_bits(0, 3, 11), str2v("00110101111")); end
        n_cmp++; if (cyc_err(0, 3, "00110101111") !== 0) begin n_bad++; $display("FAIL t2_odd_width: got %0d wrong cycles expected 0", cyc_err(0, 3, "00110101111")); end
    endtask

    task automatic test_fifo_full();
        logic [8:0] words [6];
        int acc;
        int w;
        words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
        do_reset();
        set_cfg(3, 0, 0, 2, 0, 0);
        tx_en = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            wr_vld = 1'b1;
            wr_dat = words[i];
            if (wr_rdy === 1'b1) acc++;
            @(negedge clk);
        end
        wr_vld = 1'b0;
        n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL t3_accepted: got %0d expected 4", acc); end
        n_cmp++; if (wr_rdy !== 1'b0 || fifo_cnt !== 3'd4) begin n_bad++; $display("FAIL t3_full: got rdy=%b cnt=%0d expected rdy=0 cnt=4", wr_rdy, fifo_cnt); end
        n_cmp++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL t3_disabled_idle: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy); end
        tx_en = 1'b1;
        wait_low(10, w);
        n_cmp++; if (w !== 1) begin n_bad++; $display("FAIL t3_enable_latency: got %0d expected 1", w); end
        record(81, -1);
        n_cmp++; if (frame_bits(0, 2, 10) !== str2v("0100010001")) begin n_bad++; $display("FAIL t3_frame0: got %h expected %h", frame_bits(0, 2, 10), str2v("0100010001")); end
        n_cmp++; if (frame_bits(20, 2, 10) !== str2v("0010001001")) begin n_bad++; $display("FAIL t3_frame1: got %h expected %h", frame_bits(20, 2, 10), str2v("0010001001")); end
        n_cmp++; if (frame_bits(40, 2, 10) !== str2v("0110011001")) begin n_bad++; $display("FAIL t3_frame2: got %h expected %h", frame_bits(40, 2, 10), str2v("0110011001")); end
        n_cmp++; if (frame_bits(60, 2, 10) !== str2v("0001000101")) begin n_bad++; $display("FAIL t3_frame3: got %h expected %h", frame_bits(60, 2, 10), str2v("0001000101")); end
        n_cmp++; if (done_count(0, 80) !== 4 || samp_done[20] !== 1'b1 || samp_done[40] !== 1'b1 || samp_done[60] !== 1'b1 || samp_done[80] !== 1'b1) begin
            n_bad++; $display("FAIL t3_done: got count=%0d expected 4 at 20/40/60/80", done_count(0, 80)); end
        n_cmp++; if (fifo_cnt !== 3'd0 || wr_rdy !== 1'b1) begin n_bad++; $display("FAIL t3_drained: got cnt=%0d rdy=%b expected cnt=0 rdy=1", fifo_cnt, wr_rdy); end
    endtask

    task automatic test_cts();
        int hi;
        int w;
        do_reset();
        set_cfg(3, 0, 0, 2, 0, 0);
        cts_en = 1'b1;
        uart_cts_n = 1'b1;
        push(9'h00F);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (uart_tx === 1'b1) hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 20 || fifo_cnt !== 3'd1) begin n_bad++; $display("FAIL t4_blocked: got high=%0d cnt=%0d expected high=20 cnt=1", hi, fifo_cnt); end
        uart_cts_n = 1'b0;
        wait_low(10, w);
        n_cmp++; if (w !== 3) begin n_bad++; $display("FAIL t4_sync_latency: got %0d expected 3", w); end
        uart_cts_n = 1'b1;
        record(21, -1);
        n_cmp++; if (frame_bits(0, 2, 10) !== str2v("0111100001")) begin n_bad++; $display("FAIL t4_frame: got %h expected %h", frame_bits(0, 2, 10), str2v("0111100001")); end
        n_cmp++; if (done_count(0, 20) !== 1 || samp_done[20] !== 1'b1) begin n_bad++; $display("FAIL t4_done: got count=%0d at20=%b expected count=1 at20=1", done_count(0, 20), samp_done[20]); end
    endtask

    task automatic test_9bit();
        int w;
        do_reset();
        set_cfg(4, 0, 0, 1, 1, 2);
        push(9'h1FF);
        wait_low(20, w);
        record(25, -1);
        n_cmp++; if (frame_bits(0, 2, 12) !== str2v("011111111101")) begin n_bad++; $display("FAIL t5_odd9_frame: got %h expected %h", frame_bits(0, 2, 12), str2v("011111111101")); end
        n_cmp++; if (cyc_err(0, 2, "011111111101") !== 0 || samp_done[24] !== 1'b1) begin n_bad++; $display("FAIL t5_odd9_timing: got %0d wrong cycles done24=%b expected 0 and 1", cyc_err(0, 2, "011111111101"), samp_done[24]); end
        set_cfg(7, 0, 0, 0, 1, 3);
        push(9'h100);
        wait_low(20, w);
        record(25, -1);
        n_cmp++; if (frame_bits(0, 2, 12) !== str2v("000000000111")) begin n_bad++; $display("FAIL t5_even9_frame: got %h expected %h", frame_bits(0, 2, 12), str2v("000000000111")); end
        n_cmp++; if (cyc_err(0, 2, "000000000111") !== 0) begin n_bad++; $display("FAIL t5_div0_width: got %0d wrong cycles expected 0", cyc_err(0, 2, "000000000111")); end
    endtask

    task automatic test_break();
        int w;
        int low;
        do_reset();
        set_cfg(3, 0, 0, 2, 0, 0);
        push(9'h055);
        push(9'h0F0);
        wait_low(20, w);
        brk_req = 1'b1;
        record(53, 29);
        low = 0;
        for (int i = 20; i <= 29; i++) if (samp_tx[i] === 1'b0) low++;
        n_cmp++; if (frame_bits(0, 2, 10) !== str2v("0101010101")) begin n_bad++; $display("FAIL t6_frame_before_break: got %h expected %h", frame_bits(0, 2, 10), str2v("0101010101")); end
        n_cmp++; if (low !== 10) begin n_bad++; $display("FAIL t6_break_low: got %0d low cycles expected 10", low); end
        n_cmp++; if (samp_tx[30] !== 1'b1 || samp_tx[31] !== 1'b1) begin n_bad++; $display("FAIL t6_break_stop: got %b%b expected 11", samp_tx[30], samp_tx[31]); end
        n_cmp++; if (frame_bits(32, 2, 10) !== str2v("0000011111")) begin n_bad++; $display("FAIL t6_queued_frame: got %h expected %h", frame_bits(32, 2, 10), str2v("0000011111")); end
        n_cmp++; if (done_count(0, 52) !== 3 || samp_done[20] !== 1'b1 || samp_done[32] !== 1'b1 || samp_done[52] !== 1'b1) begin
            n_bad++; $display("FAIL t6_done: got count=%0d expected 3 at 20/32/52", done_count(0, 52)); end
    endtask

    task automatic test_reset_midframe();
        int w;
        do_reset();
        set_cfg(3, 0, 0, 2, 0, 0);
        push(9'h033);
        push(9'h044);
        wait_low(20, w);
        repeat (5) @(negedge clk);
        n_cmp++; if (fifo_cnt !== 3'd1 || tx_busy !== 1'b1) begin n_bad++; $display("FAIL t7_midframe: got cnt=%0d busy=%b expected cnt=1 busy=1", fifo_cnt, tx_busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (uart_tx !== 1'b1 || fifo_cnt !== 3'd0 || tx_busy !== 1'b0 || wr_rdy !== 1'b1) begin
            n_bad++; $display("FAIL t7_async_reset: got tx=%b cnt=%0d busy=%b rdy=%b expected 1/0/0/1", uart_tx, fifo_cnt, tx_busy, wr_rdy); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin n_bad++; $display("FAIL t7_after_reset: got tx=%b busy=%b expected tx=1 busy=0", uart_tx, tx_busy); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_fifo_full();
        test_cts();
        test_9bit();
        test_break();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
